// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: registered immediate extender with skid-buffered valid/ready stage
module imm_extend_pipe #(
  parameter int DATA_W = 32,
  parameter int BR_SHIFT = 2,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [23:0]       instr,
  input  logic [2:0]        imm_src,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ext_imm,
  output logic              out_illegal,
  output logic [CNT_W-1:0]  illegal_count
);
  logic              main_valid, skid_valid, main_ill, skid_ill, ill, acc, main_load;
  logic [DATA_W-1:0] main_imm, skid_imm, imm, br;
  logic [31:0]       rot_src;
  logic [63:0]       rot_dbl;
  logic [4:0]        rot_amt;
  always_comb begin
    rot_src = {24'b0, instr[7:0]};
    rot_amt = {instr[11:8], 1'b0};
    rot_dbl = {rot_src, rot_src} >> rot_amt;
    br = {{(DATA_W-24){instr[23]}}, instr} << BR_SHIFT;
    ill = imm_src[2] & imm_src[1];
    imm = imm_src == 3'd0 ? DATA_W'(instr[7:0]) :
          imm_src == 3'd1 ? DATA_W'(instr[11:0]) :
          imm_src == 3'd2 ? br :
          imm_src == 3'd3 ? DATA_W'(rot_dbl[31:0]) :
          imm_src == 3'd4 ? {{(DATA_W-12){instr[11]}}, instr[11:0]} :
          imm_src == 3'd5 ? DATA_W'({instr[19:16], instr[11:0]}) : '0;
  end
  assign in_ready = !skid_valid;
  assign acc = in_valid && in_ready;
  assign main_load = !main_valid || out_ready;
  assign out_valid = main_valid;
  assign ext_imm = main_imm;
  assign out_illegal = main_ill;
  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_imm <= '0;
      main_ill <= 1'b0;
      skid_imm <= '0;
      skid_ill <= 1'b0;
      illegal_count <= '0;
    end else begin
      if (acc && ill && !flush && illegal_count != '1) illegal_count <= illegal_count + 1'b1;
      if (flush) begin
        main_valid <= 1'b0;
        skid_valid <= 1'b0;
      end else if (main_load) begin
        main_valid <= skid_valid || acc;
        skid_valid <= 1'b0;
        if (skid_valid || acc) begin
          main_imm <= skid_valid ? skid_imm : imm;
          main_ill <= skid_valid ? skid_ill : ill;
        end
      end else if (acc) begin
        skid_valid <= 1'b1;
        skid_imm <= imm;
        skid_ill <= ill;
      end
    end
  end
endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: table-driven and sequence checks for imm_extend_pipe (32-bit and 64-bit/2-bit-counter builds)
module tb_imm_extend_pipe;
  logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [23:0] instr = '0;
  logic [2:0]  imm_src = '0;
  logic        ir0, ov0, ill0, ir1, ov1, ill1;
  logic [31:0] ext32;
  logic [63:0] ext64;
  logic [7:0]  cnt0;
  logic [1:0]  cnt1;
  int total = 0, bad = 0;

  typedef struct packed {
    logic [23:0] instr;
    logic [2:0]  src;
    logic [31:0] e32;
    logic [63:0] e64;
    logic        ill;
  } vec_t;
  vec_t tbl [14];

  always #5 clk = ~clk;

  imm_extend_pipe u0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir0), .instr(instr),
    .imm_src(imm_src), .flush(flush), .out_valid(ov0), .out_ready(out_ready),
    .ext_imm(ext32), .out_illegal(ill0), .illegal_count(cnt0)
  );
  imm_extend_pipe #(.DATA_W(64), .BR_SHIFT(2), .CNT_W(2)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir1), .instr(instr),
    .imm_src(imm_src), .flush(flush), .out_valid(ov1), .out_ready(out_ready),
    .ext_imm(ext64), .out_illegal(ill1), .illegal_count(cnt1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [23:0] i, input logic [2:0] s);
    in_valid = v;
    instr = i;
    imm_src = s;
  endtask

  initial begin
    tbl[0]  = '{24'h000AFF, 3'd0, 32'h000000FF, 64'h00000000000000FF, 1'b0};
    tbl[1]  = '{24'hABCDEF, 3'd1, 32'h00000DEF, 64'h0000000000000DEF, 1'b0};
    tbl[2]  = '{24'h800001, 3'd2, 32'hFE000004, 64'hFFFFFFFFFE000004, 1'b0};
    tbl[3]  = '{24'h000001, 3'd2, 32'h00000004, 64'h0000000000000004, 1'b0};
    tbl[4]  = '{24'h0002FF, 3'd3, 32'hF000000F, 64'h00000000F000000F, 1'b0};
    tbl[5]  = '{24'h000AFF, 3'd3, 32'h000FF000, 64'h00000000000FF000, 1'b0};
    tbl[6]  = '{24'h0000FF, 3'd3, 32'h000000FF, 64'h00000000000000FF, 1'b0};
    tbl[7]  = '{24'h000800, 3'd4, 32'hFFFFF800, 64'hFFFFFFFFFFFFF800, 1'b0};
    tbl[8]  = '{24'h0007FF, 3'd4, 32'h000007FF, 64'h00000000000007FF, 1'b0};
    tbl[9]  = '{24'h0F0123, 3'd5, 32'h0000F123, 64'h000000000000F123, 1'b0};
    tbl[10] = '{24'h123456, 3'd6, 32'h00000000, 64'h0000000000000000, 1'b1};
    tbl[11] = '{24'hFFFFFF, 3'd7, 32'h00000000, 64'h0000000000000000, 1'b1};
    tbl[12] = '{24'hFFFFFF, 3'd2, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    tbl[13] = '{24'h0001FF, 3'd3, 32'hC000003F, 64'h00000000C000003F, 1'b0};

    step();
    step();
    chk("rst_out_valid", {63'b0, ov0}, 64'd0);
    chk("rst_in_ready", {63'b0, ir0}, 64'd1);
    chk("rst_ext_imm", {32'b0, ext32}, 64'd0);
    chk("rst_illegal", {63'b0, ill0}, 64'd0);
    chk("rst_count", {56'b0, cnt0}, 64'd0);
    reset = 1'b0;
    out_ready = 1'b1;

    for (int i = 0; i < 14; i++) begin
      drive(1'b1, tbl[i].instr, tbl[i].src);
      step();
      chk($sformatf("vec%0d_valid", i), {62'b0, ov0, ov1}, 64'd3);
      chk($sformatf("vec%0d_ext32", i), {32'b0, ext32}, {32'b0, tbl[i].e32});
      chk($sformatf("vec%0d_ext64", i), ext64, tbl[i].e64);
      chk($sformatf("vec%0d_illegal", i), {62'b0, ill0, ill1}, {62'b0, tbl[i].ill, tbl[i].ill});
    end
    drive(1'b0, 24'h0, 3'd0);
    step();
    chk("drain_valid", {63'b0, ov0}, 64'd0);
    chk("cnt_after_table", {54'b0, cnt1, cnt0}, {54'b0, 2'd2, 8'd2});

    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 24'h00ABCD, 3'd7);
      step();
      if (k == 0) chk("ill_out", {31'b0, ill0, ext32}, {31'b0, 1'b1, 32'h0});
    end
    drive(1'b0, 24'h0, 3'd0);
    step();
    chk("cnt_sat", {54'b0, cnt1, cnt0}, {54'b0, 2'd3, 8'd5});

    out_ready = 1'b0;
    drive(1'b1, 24'h000011, 3'd0);
    step();
    chk("bp_a_head", {31'b0, ov0, ext32}, {31'b0, 1'b1, 32'h11});
    chk("bp_ready_a", {63'b0, ir0}, 64'd1);
    drive(1'b1, 24'h000022, 3'd0);
    step();
    chk("bp_ready_b", {63'b0, ir0}, 64'd0);
    chk("bp_a_hold", {32'b0, ext32}, 64'h11);
    drive(1'b1, 24'h000033, 3'd0);
    step();
    chk("bp_c_blocked", {62'b0, ir0, ov0}, 64'd1);
    chk("bp_a_hold2", {32'b0, ext32}, 64'h11);
    out_ready = 1'b1;
    step();
    chk("bp_b_out", {31'b0, ov0, ext32}, {31'b0, 1'b1, 32'h22});
    chk("bp_ready_back", {63'b0, ir0}, 64'd1);
    step();
    chk("bp_c_out", {31'b0, ov0, ext32}, {31'b0, 1'b1, 32'h33});
    drive(1'b0, 24'h0, 3'd0);
    step();
    chk("bp_empty", {63'b0, ov0}, 64'd0);

    out_ready = 1'b0;
    drive(1'b1, 24'h000044, 3'd0);
    step();
    drive(1'b1, 24'h000055, 3'd0);
    step();
    chk("fl_full_ready", {63'b0, ir0}, 64'd0);
    flush = 1'b1;
    drive(1'b1, 24'h000066, 3'd7);
    step();
    flush = 1'b0;
    chk("fl1_valid_ready", {62'b0, ov0, ir0}, 64'd1);
    drive(1'b1, 24'h000077, 3'd0);
    step();
    flush = 1'b1;
    drive(1'b1, 24'h000088, 3'd7);
    step();
    flush = 1'b0;
    chk("fl2_valid_ready", {62'b0, ov0, ir0}, 64'd1);
    chk("fl2_no_count", {56'b0, cnt0}, 64'd5);
    drive(1'b0, 24'h0, 3'd0);
    out_ready = 1'b1;
    step();
    chk("fl_nothing_out", {63'b0, ov0}, 64'd0);

    out_ready = 1'b0;
    drive(1'b1, 24'h000099, 3'd1);
    step();
    chk("rs_pre_valid", {63'b0, ov0}, 64'd1);
    reset = 1'b1;
    flush = 1'b1;
    drive(1'b1, 24'h0000AA, 3'd7);
    step();
    chk("rs_valid_ready", {62'b0, ov0, ir0}, 64'd1);
    chk("rs_data", {31'b0, ill0, ext32}, 64'd0);
    chk("rs_counts", {54'b0, cnt1, cnt0}, 64'd0);
    reset = 1'b0;
    flush = 1'b0;
    drive(1'b0, 24'h0, 3'd0);
    step();
    chk("rs_after", {55'b0, ov0, cnt0}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
